fp_align_unit: RTL and testbench
================================

// Module: fp_align_unit
// PURPOSE
//  Operand-alignment stage for the floating-point adder. Accepts two IEEE-754-style operands, orders them by magnitude,
//  and right-shifts the smaller mantissa onto the larger exponent with guard/round/sticky retention.
//  It shifts up to STEP bits per cycle under an FSM, with valid/ready handshakes on both sides.
//  It feeds the mantissa add/sub stage.
// PARAMETERS
//  EXP_W   8   exponent width
//  MAN_W   23  stored fraction width (hidden bit not stored)
//  STEP    4   max right-shift distance per SHIFT cycle (1..MAN_W+4)
// PORTS
//  clk        in   1              rising-edge clock
//  res        in   1              asynchronous active-low reset
//  in_valid   in   1              operand pair present
//  in_ready   out  1              unit can accept a pair (high only in IDLE)
//  a          in   1+EXP_W+MAN_W  operand A {sign,exp,frac}
//  b          in   1+EXP_W+MAN_W  operand B {sign,exp,frac}
//  out_valid  out  1              aligned result present
//  out_ready  in   1              downstream accepts result
//  big_sign   out  1              sign of larger-magnitude operand
//  small_sign out  1              sign of smaller-magnitude operand
//  exp_out    out  EXP_W          common (larger) effective exponent
//  big_man    out  MAN_W+4        {hidden,frac,3'b000}
//  small_man  out  MAN_W+4        aligned {hidden,frac,G,R,S}
//  swapped    out  1              1 = B was the larger operand
// BEHAVIOUR
//  - Reset (res low, async): state=IDLE; all outputs 0, including in_ready.
//    in_ready rises at the first rising edge with res high.
//  - Extended mantissa: hidden=1 if exp!=0, else hidden=0 and effective exp=1 (denormal).
//    Layout {hidden,frac,3'b000}. Exp all-ones gets no special handling (NaN/Inf are upstream's job).
//  - Ordering: swap if effB>effA, or effB==effA and manB>manA. On full equality A is big (swapped=0).
//  - FSM IDLE -> CMP -> [SHIFT]* -> DONE -> IDLE.
//  - IDLE: in_ready=1. At a rising edge with in_valid=1, latch a,b, go to CMP, and drop in_ready.
//  - CMP (1 cycle): order operands; d = effBig - effSmall; load big fields and exp_out.
//    - d >= MAN_W+4: small_man = {0..0, |small_ext}, go to DONE (pure-sticky bypass).
//    - d == 0: go to DONE unshifted.
//    - otherwise: rem=d, go to SHIFT.
//  - SHIFT: each edge shifts right by s=min(rem,STEP), sets rem -= s, and ORs all shifted-out bits into bit 0 (sticky).
//    Sticky stays set once set. Go to DONE when rem hits 0.
//  - Latency: the accepting edge is edge 0. out_valid goes high after edge k+1, where k=ceil(d/STEP)
//    (k=0 for the d==0 and bypass cases).
//  - DONE: out_valid=1. All outputs held stable while out_ready=0.
//    At an edge with out_ready=1: go to IDLE, out_valid->0, in_ready->1. No overlap between operations.
//  - in_valid is ignored outside IDLE. Inputs are not required to stay stable after acceptance.
//  - Reset asserted mid-operation aborts immediately. No partial result is ever presented.
//  - Data outputs are registered. They keep the last result after out_valid falls until the next CMP.
// TESTING (EXP_W=8, MAN_W=23, STEP=4; outputs hex, 27-bit mantissas)
//  1. a=3F800000, b=3F000000 -> d=1, out_valid after edge 2; exp_out=7F, big_man=4000000,
//     small_man=2000000, swapped=0.
//  2. a=3F000000, b=40000000 -> swapped=1, exp_out=80, big_man=4000000, small_man=1000000, out_valid after edge 2.
//  3. a=4B800000, b=3F800001 -> d=24, k=6, out_valid after edge 7; small_man=0000005 (G=1, S=1), exp_out=97.
//  4. a=7F000000, b=3F800000 -> d=127 bypass, out_valid after edge 1; small_man=0000001, big_man=4000000.
//  5. Case 1 with out_ready=0 for 5 cycles -> outputs stable, in_ready=0, and in_valid pulses ignored;
//     raise out_ready -> out_valid=0 and in_ready=1 one edge later.
//  6. Assert res mid-SHIFT of case 3 -> out_valid=0 and in_ready=0 asynchronously;
//     after release, rerun case 2 -> exact case-2 results.

Source files
------------

// File: rtl/fp_align_unit.sv
// Operand-alignment stage for the floating-point adder.
// Orders two operands by magnitude, then right-shifts the smaller mantissa
// onto the larger exponent (up to STEP bits per cycle) keeping guard/round/sticky.
module fp_align_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int STEP  = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   big_sign,
  output logic                   small_sign,
  output logic [EXP_W-1:0]       exp_out,
  output logic [MAN_W+3:0]       big_man,
  output logic [MAN_W+3:0]       small_man,
  output logic                   swapped
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;
  localparam logic [EXP_W-1:0] STEP_V = EXP_W'(STEP);

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [EXP_W-1:0] r_rem;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_bigSign;
  logic             r_smallSign;
  logic [EXP_W-1:0] r_exp;
  logic [MW-1:0]    r_bigMan;
  logic [MW-1:0]    r_smallMan;
  logic             r_swapped;

  logic [EXP_W-1:0] w_expA, w_expB, w_effA, w_effB;
  logic [MW-1:0]    w_manA, w_manB;
  logic             w_swap, w_accept, w_bypass;
  logic [EXP_W-1:0] w_effBig, w_effSmall, w_diff;
  logic [MW-1:0]    w_manBig, w_manSmall;
  logic             w_signBig, w_signSmall;
  logic [EXP_W-1:0] w_stepAmt, w_remNext;
  logic [MW-1:0]    w_lostMask, w_shifted, w_shiftedSticky;
  logic             w_lost;

  // Denormals (exp==0) get no hidden bit and an effective exponent of 1.
  assign w_expA = r_a[W-2 -: EXP_W];
  assign w_expB = r_b[W-2 -: EXP_W];
  assign w_effA = (w_expA == '0) ? EXP_W'(1) : w_expA;
  assign w_effB = (w_expB == '0) ? EXP_W'(1) : w_expB;
  assign w_manA = {(w_expA != '0), r_a[MAN_W-1:0], 3'b000};
  assign w_manB = {(w_expB != '0), r_b[MAN_W-1:0], 3'b000};

  // B wins only when strictly larger; full equality keeps A as the big operand.
  assign w_swap      = (w_effB > w_effA) || ((w_effB == w_effA) && (w_manB > w_manA));
  assign w_effBig    = w_swap ? w_effB : w_effA;
  assign w_effSmall  = w_swap ? w_effA : w_effB;
  assign w_manBig    = w_swap ? w_manB : w_manA;
  assign w_manSmall  = w_swap ? w_manA : w_manB;
  assign w_signBig   = w_swap ? r_b[W-1] : r_a[W-1];
  assign w_signSmall = w_swap ? r_a[W-1] : r_b[W-1];
  assign w_diff      = w_effBig - w_effSmall;
  assign w_bypass    = ({1'b0, w_diff} >= (EXP_W+1)'(MW));

  // One shift step: everything falling off the bottom collapses into bit 0.
  assign w_stepAmt       = (r_rem > STEP_V) ? STEP_V : r_rem;
  assign w_remNext       = r_rem - w_stepAmt;
  assign w_lostMask      = ~({MW{1'b1}} << w_stepAmt);
  assign w_lost          = |(r_smallMan & w_lostMask);
  assign w_shifted       = r_smallMan >> w_stepAmt;
  assign w_shiftedSticky = {w_shifted[MW-1:1], w_shifted[0] | w_lost};

  assign w_accept = (r_state == IDLE) && r_inReady && in_valid;

  // Next-state selection for the IDLE -> CMP -> SHIFT* -> DONE sequence.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = CMP;
      CMP:     w_nextState = (w_bypass || (w_diff == '0)) ? DONE : SHIFT;
      SHIFT:   if (w_remNext == '0) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register; in_ready/out_valid are registered from the next state so
  // both stay low during reset and in_ready rises on the first clock after it.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= (w_nextState == IDLE);
      r_outValid <= (w_nextState == DONE);
    end
  end

  // Operand capture, ordering in CMP and iterative shifting in SHIFT.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_bigSign   <= 1'b0;
      r_smallSign <= 1'b0;
      r_exp       <= '0;
      r_bigMan    <= '0;
      r_smallMan  <= '0;
      r_swapped   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= a;
        r_b <= b;
      end
      if (r_state == CMP) begin
        r_bigSign   <= w_signBig;
        r_smallSign <= w_signSmall;
        r_exp       <= w_effBig;
        r_bigMan    <= w_manBig;
        r_swapped   <= w_swap;
        r_rem       <= w_diff;
        if (w_bypass) r_smallMan <= {{(MW-1){1'b0}}, |w_manSmall};
        else          r_smallMan <= w_manSmall;
      end
      if (r_state == SHIFT) begin
        r_smallMan <= w_shiftedSticky;
        r_rem      <= w_remNext;
      end
    end
  end

  assign in_ready   = r_inReady;
  assign out_valid  = r_outValid;
  assign big_sign   = r_bigSign;
  assign small_sign = r_smallSign;
  assign exp_out    = r_exp;
  assign big_man    = r_bigMan;
  assign small_man  = r_smallMan;
  assign swapped    = r_swapped;

endmodule

// File: tb/tb_fp_align_unit.sv
// Directed self-checking bench for fp_align_unit (EXP_W=8, MAN_W=23, STEP=4).
module tb_fp_align_unit;

  logic        clk;
  logic        res;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        big_sign;
  logic        small_sign;
  logic [7:0]  exp_out;
  logic [26:0] big_man;
  logic [26:0] small_man;
  logic        swapped;

  int checkCount;
  int passCount;

  typedef struct packed {
    logic [31:0] va;
    logic [31:0] vb;
    logic [7:0]  lat;
    logic [7:0]  ex;
    logic [26:0] big;
    logic [26:0] sml;
    logic        sw;
    logic        bs;
    logic        ss;
  } vec_t;

  vec_t vecs [0:11];

  fp_align_unit #(.EXP_W(8), .MAN_W(23), .STEP(4)) dut (
    .clk        (clk),
    .res        (res),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_sign   (big_sign),
    .small_sign (small_sign),
    .exp_out    (exp_out),
    .big_man    (big_man),
    .small_man  (small_man),
    .swapped    (swapped)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_in_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    res = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #2;
    checkCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready); else passCount++;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); else passCount++;
    checkCount++;
    if ({big_sign, small_sign, exp_out, big_man, small_man, swapped} !== '0)
      $display("[TB] FAIL reset_data: got exp=%h big=%h small=%h required all zero", exp_out, big_man, small_man);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_held_in_ready: got %b required 0", in_ready); else passCount++;
    res = 1'b1;
    #1;
    checkCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL release_before_edge: got %b required 0", in_ready); else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL release_first_edge: got %b required 1", in_ready); else passCount++;
  endtask

  task automatic test_align();
    int n;
    vecs[0]  = '{32'h3F800000, 32'h3F000000, 8'd2, 8'h7F, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h3F000000, 32'h40000000, 8'd2, 8'h80, 27'h4000000, 27'h1000000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h4B800000, 32'h3F800001, 8'd7, 8'h97, 27'h4000000, 27'h0000005, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h7F000000, 32'h3F800000, 8'd1, 8'hFE, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'hBF800000, 32'h3F000000, 8'd2, 8'h7F, 27'h4000000, 27'h2000000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'h40400000, 32'h40400000, 8'd1, 8'h80, 27'h6000000, 27'h6000000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h3F800000, 32'hBFC00000, 8'd1, 8'h7F, 27'h6000000, 27'h4000000, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'h00000001, 32'h00800000, 8'd1, 8'h01, 27'h4000000, 27'h0000008, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'h4D000000, 32'h3F800000, 8'd1, 8'h9A, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h4C800000, 32'h3F800000, 8'd8, 8'h99, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h42000000, 32'h3F800000, 8'd3, 8'h84, 27'h4000000, 27'h0200000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h41800000, 32'h3F800000, 8'd2, 8'h83, 27'h4000000, 27'h0400000, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_in_ready(n);
      a = vecs[i].va; b = vecs[i].vb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
      checkCount++;
      if (in_ready !== 1'b0) $display("[TB] FAIL vec%0d_busy: in_ready got %b required 0", i, in_ready); else passCount++;
      wait_out_valid(n);
      checkCount++;
      if (n !== int'(vecs[i].lat)) $display("[TB] FAIL vec%0d_latency: got %0d required %0d", i, n, vecs[i].lat); else passCount++;
      checkCount++;
      if (exp_out !== vecs[i].ex) $display("[TB] FAIL vec%0d_exp: got %h required %h", i, exp_out, vecs[i].ex); else passCount++;
      checkCount++;
      if (big_man !== vecs[i].big) $display("[TB] FAIL vec%0d_big_man: got %h required %h", i, big_man, vecs[i].big); else passCount++;
      checkCount++;
      if (small_man !== vecs[i].sml) $display("[TB] FAIL vec%0d_small_man: got %h required %h", i, small_man, vecs[i].sml); else passCount++;
      checkCount++;
      if (swapped !== vecs[i].sw) $display("[TB] FAIL vec%0d_swapped: got %b required %b", i, swapped, vecs[i].sw); else passCount++;
      checkCount++;
      if ({big_sign, small_sign} !== {vecs[i].bs, vecs[i].ss})
        $display("[TB] FAIL vec%0d_signs: got %b%b required %b%b", i, big_sign, small_sign, vecs[i].bs, vecs[i].ss);
      else passCount++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    wait_in_ready(n);
    out_ready = 1'b0;
    a = 32'h3F800000; b = 32'h3F000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(n);
    checkCount++;
    if (n !== 2) $display("[TB] FAIL bp_latency: got %0d required 2", n); else passCount++;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000;
      @(posedge clk); #1;
      checkCount++;
      if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid%0d: got %b required 1", c, out_valid); else passCount++;
      checkCount++;
      if (in_ready !== 1'b0) $display("[TB] FAIL bp_hold_ready%0d: got %b required 0", c, in_ready); else passCount++;
      checkCount++;
      if ({exp_out, big_man, small_man, swapped} !== {8'h7F, 27'h4000000, 27'h2000000, 1'b0})
        $display("[TB] FAIL bp_hold_data%0d: got exp=%h big=%h small=%h sw=%b required 7f 4000000 2000000 0",
                 c, exp_out, big_man, small_man, swapped);
      else passCount++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b required 0", out_valid); else passCount++;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b required 1", in_ready); else passCount++;
    checkCount++;
    if (small_man !== 27'h2000000) $display("[TB] FAIL bp_keep_result: got %h required 2000000", small_man); else passCount++;
  endtask

  task automatic test_reset_mid_shift();
    int n;
    wait_in_ready(n);
    out_ready = 1'b1;
    a = 32'h4B800000; b = 32'h3F800001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    res = 1'b0;
    #1;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL abort_out_valid: got %b required 0", out_valid); else passCount++;
    checkCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL abort_in_ready: got %b required 0", in_ready); else passCount++;
    checkCount++;
    if ({exp_out, small_man} !== '0) $display("[TB] FAIL abort_data: got exp=%h small=%h required 0", exp_out, small_man); else passCount++;
    #2;
    res = 1'b1;
    wait_in_ready(n);
    checkCount++;
    if (n !== 1) $display("[TB] FAIL abort_recover: in_ready edges got %0d required 1", n); else passCount++;
    a = 32'h3F000000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(n);
    checkCount++;
    if (n !== 2) $display("[TB] FAIL rerun_latency: got %0d required 2", n); else passCount++;
    checkCount++;
    if ({exp_out, big_man, small_man, swapped} !== {8'h80, 27'h4000000, 27'h1000000, 1'b1})
      $display("[TB] FAIL rerun_data: got exp=%h big=%h small=%h sw=%b required 80 4000000 1000000 1",
               exp_out, big_man, small_man, swapped);
    else passCount++;
    @(posedge clk); #1;
  endtask

  // Scenario sequence and summary.
  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_align();
    test_backpressure();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
